opcode_sequencer: RTL



---
 rtl/opcode_sequencer_pkg.sv | 12 +
 rtl/opcode_sequencer_program_store.sv | 20 ++
 rtl/opcode_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/opcode_sequencer_pkg.sv
// opcode_sequencer_pkg: shared types and constants for the opcode sequencer and its program store.
package opcode_sequencer_pkg;
  localparam int OP_W = 20;
  localparam logic [OP_W-1:0] NOP = '0;
  localparam int OP_HI = 19;
  localparam int OP_LO = 16;
  localparam int A_HI = 15;
  localparam int A_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RELEASE, FINISH} seqState_t;
endpackage

// File: rtl/opcode_sequencer_program_store.sv
// opcode_sequencer_program_store: DEPTH x OP_W program memory, one sync write port and one registered read port.
module opcode_sequencer_program_store
  import opcode_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [OP_W-1:0]   WrData,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [OP_W-1:0]   RdData
);
  logic [OP_W-1:0] mem [DEPTH];
  always_ff @(posedge Clock) begin
    if (WrEn) mem[WrAddr] <= WrData;
    RdData <= mem[RdAddr];
  end
endmodule

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: issues a loaded opcode program over the OpCode/Done handshake with a per-edge watchdog.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [OP_W-1:0]   LoadData,
  input  logic [ADDR_W:0]   Length,
  input  logic              Start,
  input  logic              Abort,
  output logic [OP_W-1:0]   OpCode,
  input  logic              Done,
  output logic [ADDR_W-1:0] Pc,
  output logic              Busy,
  output logic              Finished,
  output logic              Error
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  seqState_t state, stateNext;
  logic [OP_W-1:0] rdData, opNext;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W:0] len, lenNext;
  logic [WD_W-1:0] watchdog, wdNext;
  logic readReady, readyNext, errNext, lastWord, timeoutHit;
  opcode_sequencer_program_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) store (
    .Clock(Clock),
    .WrEn(LoadEn && !Busy),
    .WrAddr(LoadAddr),
    .WrData(LoadData),
    .RdAddr(Pc),
    .RdData(rdData)
  );
  assign Busy = state != IDLE;
  assign Finished = state == FINISH;
  assign lastWord = {1'b0, Pc} == len - 1'b1;
  assign timeoutHit = watchdog == WD_LAST;
  // FETCH spends one cycle for the registered read of mem[Pc], then acts on the word.
  always_comb begin
    stateNext = state;
    opNext = OpCode;
    pcNext = Pc;
    lenNext = len;
    wdNext = watchdog;
    errNext = Error;
    readyNext = 1'b0;
    if (Abort) begin
      stateNext = IDLE;
      opNext = NOP;
    end else begin
      case (state)
        IDLE: if (Start) begin
          if (Length != '0) begin
            lenNext = (Length > DEPTH_L) ? DEPTH_L : Length;
            pcNext = '0;
            errNext = 1'b0;
            stateNext = FETCH;
          end else stateNext = FINISH;
        end
        FETCH: if (!readReady) readyNext = 1'b1;
        else if (rdData != NOP) begin
          opNext = rdData;
          wdNext = '0;
          stateNext = ISSUE;
        end else if (lastWord) stateNext = FINISH;
        else pcNext = Pc + 1'b1;
        ISSUE: if (Done) begin
          opNext = NOP;
          wdNext = '0;
          stateNext = RELEASE;
        end else if (timeoutHit) begin
          errNext = 1'b1;
          opNext = NOP;
          stateNext = IDLE;
        end else wdNext = watchdog + 1'b1;
        RELEASE: if (!Done) begin
          stateNext = lastWord ? FINISH : FETCH;
          pcNext = lastWord ? Pc : Pc + 1'b1;
        end else if (timeoutHit) begin
          errNext = 1'b1;
          stateNext = IDLE;
        end else wdNext = watchdog + 1'b1;
        FINISH: stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      OpCode <= NOP;
      Pc <= '0;
      len <= '0;
      watchdog <= '0;
      Error <= 1'b0;
      readReady <= 1'b0;
    end else begin
      state <= stateNext;
      OpCode <= opNext;
      Pc <= pcNext;
      len <= lenNext;
      watchdog <= wdNext;
      Error <= errNext;
      readReady <= readyNext;
    end
  end
endmodule
